multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 28 ++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Controller bundle: decoder/memory inputs and datapath strobes.
//   master : the controller (consumes decode/ack, drives requests and strobes)
//   slave  : the datapath/memory side
interface multicycle_ctrl_if;
  logic [6:0] op_code;
  logic [2:0] funt3;
  logic       br_taken;
  logic       im_ack;
  logic       dm_ack;
  logic       im_req;
  logic       dm_req;
  logic       dm_we;
  logic       ir_we;
  logic       rf_we;
  logic       pc_we;
  logic       pc_sel;
  logic [1:0] wb_sel;

  modport master (
    input  op_code, funt3, br_taken, im_ack, dm_ack,
    output im_req, dm_req, dm_we, ir_we, rf_we, pc_we, pc_sel, wb_sel
  );

  modport slave (
    output op_code, funt3, br_taken, im_ack, dm_ack,
    input  im_req, dm_req, dm_we, ir_we, rf_we, pc_we, pc_sel, wb_sel
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-style control FSM: IF -> ID -> EX -> (MEM) -> (WB) -> IF,
// with a terminal TRAP state for illegal opcodes and a retired-instruction count.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : decoder/ack inputs and datapath/memory strobes (combinational
//              decode of the current state and inputs)
//   state    : current FSM state (IF=0 .. TRAP=5)
//   illegal  : sticky illegal-instruction flag
//   instret  : retired-instruction counter, wraps at 2^DATA_SIZE
module multicycle_ctrl #(
  parameter int unsigned DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_ctrl_if.master    bus,
  output logic [2:0]           state,
  output logic                 illegal,
  output logic [DATA_SIZE-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_e               state_q, state_d;
  logic                 illegal_q, illegal_d;
  logic [DATA_SIZE-1:0] instret_q, instret_d;

  logic       legal;
  logic       retire;
  logic       im_req, dm_req, dm_we, ir_we, rf_we, pc_we, pc_sel;
  logic [1:0] wb_sel;

  // Opcode legality; JALR additionally requires funct3 == 000.
  always_comb begin
    legal = 1'b0;
    case (bus.op_code)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
      OP_JALR:                  legal = (bus.funt3 == 3'b000);
      default:                  legal = 1'b0;
    endcase
  end

  // Next-state, strobes and retirement.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    instret_d = instret_q;
    retire    = 1'b0;
    im_req    = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    wb_sel    = 2'd0;

    case (state_q)
      S_IF: begin
        im_req = 1'b1;
        if (bus.im_ack) begin
          ir_we   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        if (legal) begin
          state_d = S_EX;
        end else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_EX: begin
        if (bus.op_code == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = bus.br_taken;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (bus.op_code == OP_LOAD || bus.op_code == OP_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dm_req = 1'b1;
        dm_we  = (bus.op_code == OP_STORE);
        if (bus.dm_ack) begin
          if (bus.op_code == OP_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = (bus.op_code == OP_JAL || bus.op_code == OP_JALR);
        retire  = 1'b1;
        state_d = S_IF;
        case (bus.op_code)
          OP_LOAD:         wb_sel = 2'd1;
          OP_JAL, OP_JALR: wb_sel = 2'd2;
          OP_LUI:          wb_sel = 2'd3;
          default:         wb_sel = 2'd0;
        endcase
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IF;
    endcase

    if (retire) instret_d = instret_q + DATA_SIZE'(1);

    // Reset is asynchronous, so strobes must be silenced combinationally too.
    if (!rst) begin
      im_req = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
      ir_we  = 1'b0;
      rf_we  = 1'b0;
      pc_we  = 1'b0;
      pc_sel = 1'b0;
      wb_sel = 2'd0;
    end
  end

  // State, sticky flag and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  assign bus.im_req = im_req;
  assign bus.dm_req = dm_req;
  assign bus.dm_we  = dm_we;
  assign bus.ir_we  = ir_we;
  assign bus.rf_we  = rf_we;
  assign bus.pc_we  = pc_we;
  assign bus.pc_sel = pc_sel;
  assign bus.wb_sel = wb_sel;
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign instret    = instret_q;

endmodule
